// File: rtl/idct_pkg.sv
// Shared constants and sideband type for the 8-point streaming IDCT.
// The DCT coefficient magnitudes are round(256*cos(k*pi/16)). C4 also carries the 1/sqrt2 DC weight.
package idct_pkg;

  localparam int NUM_LANES  = 8;
  localparam int NUM_STAGES = 5;
  localparam int SHIFT_W    = 5;

  localparam int C1 = 251;
  localparam int C2 = 237;
  localparam int C3 = 213;
  localparam int C4 = 181;
  localparam int C5 = 142;
  localparam int C6 = 98;
  localparam int C7 = 50;

  // Per-beat controls that ride down the pipeline alongside the data.
  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic               level_en;
    logic               sat_en;
  } side_t;

  // Odd-part coefficient magnitude. The index j selects c1, c3, c5 or c7.
  function automatic int odd_coef(input int j);
    case (j)
      0:       return C1;
      1:       return C3;
      2:       return C5;
      default: return C7;
    endcase
  endfunction

endpackage

// File: rtl/idct8_butterfly.sv
// Even/odd butterfly for the 8-point IDCT, purely combinational.
// The first half reduces the registered products to partial sums. The second half
// combines the registered partial sums into the eight accumulators.
module idct8_butterfly #(
  parameter int ACC_W = 32
) (
  input  logic signed [ACC_W-1:0] pe_i  [6],
  input  logic signed [ACC_W-1:0] po_i  [4][4],
  output logic signed [ACC_W-1:0] ev_o  [4],
  output logic signed [ACC_W-1:0] od_o  [4],
  input  logic signed [ACC_W-1:0] ev_i  [4],
  input  logic signed [ACC_W-1:0] od_i  [4],
  output logic signed [ACC_W-1:0] acc_o [8]
);

  logic signed [ACC_W-1:0] even [4];

  // The entry po_i[i][j] holds in[2i+1] multiplied by the odd coefficient j (c1, c3, c5, c7).
  // The entries ev_o hold a0, a1, b0 and b1 of the even half.
  always_comb begin
    ev_o[0] = pe_i[0] + pe_i[1];
    ev_o[1] = pe_i[0] - pe_i[1];
    ev_o[2] = pe_i[2] + pe_i[5];
    ev_o[3] = pe_i[3] - pe_i[4];

    od_o[0] = po_i[0][0] + po_i[1][1] + po_i[2][2] + po_i[3][3];
    od_o[1] = po_i[0][1] - po_i[1][3] - po_i[2][0] - po_i[3][2];
    od_o[2] = po_i[0][2] - po_i[1][0] + po_i[2][3] + po_i[3][1];
    od_o[3] = po_i[0][3] - po_i[1][2] + po_i[2][1] - po_i[3][0];
  end

  always_comb begin
    even[0] = ev_i[0] + ev_i[2];
    even[1] = ev_i[1] + ev_i[3];
    even[2] = ev_i[1] - ev_i[3];
    even[3] = ev_i[0] - ev_i[2];
    for (int x = 0; x < 4; x++) begin
      acc_o[x]     = even[x] + od_i[x];
      acc_o[7 - x] = even[x] - od_i[x];
    end
  end

endmodule

// File: rtl/idct8_stream.sv
// Streaming 8-point IDCT. It is a 5-stage pipeline: multiply, add0, add1, scale and output register.
// The pipeline uses valid/ready handshaking and a single global stall.
module idct8_stream
  import idct_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [8*IN_W-1:0]    s_data,
  input  logic [SHIFT_W-1:0]   shift_amount,
  input  logic                 level_shift_en,
  input  logic                 saturate_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [8*OUT_W-1:0]   m_data
);

  localparam logic signed [ACC_W-1:0] K2    = ACC_W'(C2);
  localparam logic signed [ACC_W-1:0] K4    = ACC_W'(C4);
  localparam logic signed [ACC_W-1:0] K6    = ACC_W'(C6);
  localparam logic signed [ACC_W-1:0] LVL   = ACC_W'(1 << (OUT_W - 1));
  localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((1 << OUT_W) - 1);
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(1 << (OUT_W - 1)));

  logic                    advance;
  logic [NUM_STAGES-1:0]   vld_q;
  side_t                   side_in;
  side_t                   side_q [NUM_STAGES-1];

  logic signed [ACC_W-1:0] xin   [NUM_LANES];
  logic signed [ACC_W-1:0] pe_d  [6];
  logic signed [ACC_W-1:0] pe_q  [6];
  logic signed [ACC_W-1:0] po_d  [4][4];
  logic signed [ACC_W-1:0] po_q  [4][4];
  logic signed [ACC_W-1:0] ev_d  [4];
  logic signed [ACC_W-1:0] ev_q  [4];
  logic signed [ACC_W-1:0] od_d  [4];
  logic signed [ACC_W-1:0] od_q  [4];
  logic signed [ACC_W-1:0] acc_d [NUM_LANES];
  logic signed [ACC_W-1:0] acc_q [NUM_LANES];
  logic signed [ACC_W-1:0] r_d   [NUM_LANES];
  logic signed [ACC_W-1:0] r_q   [NUM_LANES];
  logic signed [ACC_W-1:0] rnd;
  logic [8*OUT_W-1:0]      m_data_d;
  logic [8*OUT_W-1:0]      m_data_q;

  // A stalled output register freezes every stage, so no beat can be overwritten.
  assign advance = !vld_q[NUM_STAGES-1] || m_ready;
  assign s_ready = advance;
  assign m_valid = vld_q[NUM_STAGES-1];
  assign m_data  = m_data_q;
  assign side_in = '{shift: shift_amount, level_en: level_shift_en, sat_en: saturate_en};

  // Stage 1: sign-extend each lane and form only the products the butterfly needs.
  always_comb begin
    for (int u = 0; u < NUM_LANES; u++) begin
      xin[u] = ACC_W'(signed'(s_data[u*IN_W +: IN_W]));
    end
    pe_d[0] = xin[0] * K4;
    pe_d[1] = xin[4] * K4;
    pe_d[2] = xin[2] * K2;
    pe_d[3] = xin[2] * K6;
    pe_d[4] = xin[6] * K2;
    pe_d[5] = xin[6] * K6;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        po_d[i][j] = xin[2*i+1] * ACC_W'(odd_coef(j));
      end
    end
  end

  // Stages 2 and 3: the butterfly adder trees, split across two register boundaries.
  idct8_butterfly #(
    .ACC_W (ACC_W)
  ) u_butterfly (
    .pe_i  (pe_q),
    .po_i  (po_q),
    .ev_o  (ev_d),
    .od_o  (od_d),
    .ev_i  (ev_q),
    .od_i  (od_q),
    .acc_o (acc_d)
  );

  // Stage 4: round half-up, arithmetic shift, then the optional level shift.
  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    rnd = '0;
    if (side_q[2].shift != '0) begin
      rnd = ACC_W'(1) << (side_q[2].shift - SHIFT_W'(1));
    end
    for (int x = 0; x < NUM_LANES; x++) begin
      r_d[x] = (acc_q[x] + rnd) >>> side_q[2].shift;
      if (side_q[2].level_en) begin
        r_d[x] = r_d[x] + LVL;
      end
    end
  end

  // Stage 5: clamp to the unsigned or signed output range, or wrap by truncation.
  always_comb begin
    m_data_d = '0;
    for (int x = 0; x < NUM_LANES; x++) begin
      logic signed [ACC_W-1:0] v;
      logic signed [ACC_W-1:0] lo;
      logic signed [ACC_W-1:0] hi;
      v  = r_q[x];
      lo = S_MIN;
      hi = S_MAX;
      if (side_q[3].level_en) begin
        lo = '0;
        hi = U_MAX;
      end
      if (side_q[3].sat_en) begin
        if (v < lo)      v = lo;
        else if (v > hi) v = hi;
      end
      m_data_d[x*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      m_data_q <= '0;
    end else if (advance) begin
      vld_q    <= {vld_q[NUM_STAGES-2:0], s_valid};
      m_data_q <= m_data_d;
    end
  end

  // NOTE: the datapath and sideband registers have no reset. Their contents are ignored
  // until the matching valid bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      pe_q      <= pe_d;
      po_q      <= po_d;
      ev_q      <= ev_d;
      od_q      <= od_d;
      acc_q     <= acc_d;
      r_q       <= r_d;
      side_q[0] <= side_in;
      side_q[1] <= side_q[0];
      side_q[2] <= side_q[1];
      side_q[3] <= side_q[2];
    end
  end

endmodule

// File: tb/tb_idct8_stream.sv
// Self-checking bench for idct8_stream. It combines fixed vectors, hand-written corner
// sequences and a random sweep. All of these are scored against a matrix-form IDCT model.
module tb_idct8_stream;

  localparam int IN_W  = 12;
  localparam int OUT_W = 8;
  localparam int ACC_W = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [8*IN_W-1:0]    s_data = '0;
  logic [4:0]           shift_amount = '0;
  logic                 level_shift_en = 1'b0;
  logic                 saturate_en = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic [8*OUT_W-1:0]   m_data;

  idct8_stream #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .shift_amount   (shift_amount),
    .level_shift_en (level_shift_en),
    .saturate_en    (saturate_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*IN_W-1:0]  data;
    int                 sh;
    bit                 lvl;
    bit                 sat;
    logic [8*OUT_W-1:0] exp;
    string              name;
  } vec_t;

  int                 vectors = 0;
  int                 miscompares = 0;
  int                 out_cnt = 0;
  int                 spurious = 0;
  int                 m_tab [8][8];
  logic [8*OUT_W-1:0] exp_q [$];
  logic               prev_stall = 1'b0;
  logic [8*OUT_W-1:0] prev_data = '0;
  vec_t               tbl [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: direct 8x8 matrix product with the basis built from cosines.
  function automatic logic [8*OUT_W-1:0] golden(input logic [8*IN_W-1:0] d, input int sh,
                                                input bit lvl, input bit sat);
    logic [8*OUT_W-1:0] res;
    longint             acc;
    longint             r;
    logic signed [IN_W-1:0] c;
    res = '0;
    for (int x = 0; x < 8; x++) begin
      acc = 0;
      for (int u = 0; u < 8; u++) begin
        c = d[u*IN_W +: IN_W];
        acc += longint'(c) * longint'(m_tab[x][u]);
      end
      if (sh == 0) r = acc;
      else         r = (acc + (longint'(1) << (sh - 1))) >>> sh;
      if (lvl) r += longint'(1) << (OUT_W - 1);
      if (sat) begin
        longint lo;
        longint hi;
        lo = lvl ? 0 : -(longint'(1) << (OUT_W - 1));
        hi = lvl ? (longint'(1) << OUT_W) - 1 : (longint'(1) << (OUT_W - 1)) - 1;
        if (r < lo) r = lo;
        if (r > hi) r = hi;
      end
      res[x*OUT_W +: OUT_W] = OUT_W'(r);
    end
    return res;
  endfunction

  function automatic logic [8*IN_W-1:0] lane_vec(input int u, input int v);
    logic [8*IN_W-1:0] d;
    d = '0;
    d[u*IN_W +: IN_W] = IN_W'(v);
    return d;
  endfunction

  function automatic logic [8*OUT_W-1:0] rep(input int b);
    logic [8*OUT_W-1:0] r;
    for (int x = 0; x < 8; x++) r[x*OUT_W +: OUT_W] = OUT_W'(b);
    return r;
  endfunction

  function automatic logic [8*IN_W-1:0] rand_data();
    logic [8*IN_W-1:0] d;
    for (int u = 0; u < 8; u++) d[u*IN_W +: IN_W] = IN_W'($urandom);
    return d;
  endfunction

  function automatic vec_t mk(input int u, input int v, input int sh, input bit lvl,
                              input bit sat, input logic [8*OUT_W-1:0] exp, input string name);
    vec_t t;
    t.data = lane_vec(u, v);
    t.sh   = sh;
    t.lvl  = lvl;
    t.sat  = sat;
    t.exp  = exp;
    t.name = name;
    return t;
  endfunction

  // The scoreboard samples at the falling edge. Inputs change just after the rising edge,
  // so the values sampled here are the ones the next rising edge captures.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) spurious++;
        else check("stream_data", m_data, exp_q.pop_front());
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(golden(s_data, int'(shift_amount), level_shift_en, saturate_en));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic apply_beat(input vec_t v);
    int lat;
    s_data         = v.data;
    shift_amount   = 5'(v.sh);
    level_shift_en = v.lvl;
    saturate_en    = v.sat;
    m_ready        = 1'b1;
    s_valid        = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, "_latency"}, 64'(lat), 64'd5);
    check(v.name, m_data, v.exp);
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input int n, input bit rnd_mode, input int budget);
    int sent;
    int cyc;
    int start_out;
    bit fire;
    sent      = 0;
    cyc       = 0;
    start_out = out_cnt;
    while ((sent < n || exp_q.size() != 0) && cyc < budget) begin
      if (!s_valid && sent < n && (!rnd_mode || $urandom_range(0, 4) != 0)) begin
        s_valid        = 1'b1;
        s_data         = rand_data();
        shift_amount   = rnd_mode ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 12));
        level_shift_en = 1'($urandom);
        saturate_en    = 1'($urandom);
      end
      m_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : !(cyc >= 6 && cyc <= 9);
      @(negedge clk);
      fire = s_valid && s_ready;
      @(posedge clk); #1;
      if (fire) begin
        sent++;
        s_valid = 1'b0;
      end
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("stream_in_budget", 64'(cyc < budget), 64'd1);
    check("stream_out_count", 64'(out_cnt - start_out), 64'(n));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    for (int x = 0; x < 8; x++) begin
      for (int u = 0; u < 8; u++) begin
        real k;
        real m;
        k = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        m = 256.0 * k * $cos((2.0 * x + 1.0) * u * 3.14159265358979 / 16.0);
        m_tab[x][u] = (m >= 0.0) ? $rtoi(m + 0.5) : -$rtoi(-m + 0.5);
      end
    end

    tbl.push_back(mk(0,    64, 8, 1'b0, 1'b1, rep(45),  "dc"));
    tbl.push_back(mk(0,    64, 8, 1'b1, 1'b1, rep(173), "dc_level"));
    tbl.push_back(mk(0,  2047, 4, 1'b1, 1'b1, rep(255), "sat_high"));
    tbl.push_back(mk(0,  2047, 4, 1'b1, 1'b0, rep(245), "wrap_high"));
    tbl.push_back(mk(0,   -64, 8, 1'b0, 1'b1, rep(211), "dc_neg"));
    tbl.push_back(mk(0,   -64, 8, 1'b1, 1'b1, rep(83),  "dc_neg_level"));
    tbl.push_back(mk(0,     1, 0, 1'b0, 1'b0, rep(181), "shift0_wrap"));
    tbl.push_back(mk(0,     1, 0, 1'b0, 1'b1, rep(127), "shift0_sat"));
    tbl.push_back(mk(0,     3, 2, 1'b0, 1'b0, rep(136), "round_up"));
    tbl.push_back(mk(0,    -3, 2, 1'b0, 1'b1, rep(128), "sat_signed_low"));
    tbl.push_back(mk(0, -2047, 4, 1'b1, 1'b1, rep(0),   "sat_unsigned_low"));
    tbl.push_back(mk(1,     1, 0, 1'b0, 1'b0, 64'h052B72CE328ED5FB, "basis_u1"));
    tbl.push_back(mk(2,     1, 0, 1'b0, 1'b0, 64'hED629E13139E62ED, "basis_u2"));
    tbl.push_back(mk(3,     1, 0, 1'b0, 1'b0, 64'h2B32FB8E7205CED5, "basis_u3"));
    tbl.push_back(mk(4,     1, 0, 1'b0, 1'b0, 64'hB54B4BB5B54B4BB5, "basis_u4"));

    // Reset with a beat offered: nothing may enter and the outputs must be cleared.
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = rand_data();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    rst     = 1'b0;
    s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    check("post_rst_m_valid", 64'(m_valid), 64'd0);

    for (int i = 0; i < tbl.size(); i++) apply_beat(tbl[i]);

    // Eight back-to-back beats with the output stalled for cycles 6-9.
    run_stream(8, 1'b0, 200);

    // Three beats in flight, a one-cycle reset, then no stale beat may appear.
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid        = 1'b1;
      s_data         = rand_data();
      shift_amount   = 5'd6;
      level_shift_en = 1'b1;
      saturate_en    = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_m_valid", 64'(m_valid), 64'd0);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_valid) seen++;
    end
    check("rst_mid_stale", 64'(seen), 64'd0);
    apply_beat(tbl[0]);

    run_stream(10000, 1'b1, 60000);

    repeat (4) @(posedge clk);
    #1;
    check("spurious_outputs", 64'(spurious), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
